// File: rtl/vga_fb_display_ctrl.sv
// -----------------------------------------------------------------------------
// vga_fb_display_ctrl
//
// Holds an 80x60 RGB332 framebuffer written by an MCU. Scans it out as
// 640x480@60 VGA from a 50 MHz clock, with a 25 MHz pixel rate. Each
// framebuffer cell covers a (1<<SCALE_SHIFT)^2 block of screen pixels.
//
// Ports
//   CLK               system clock; all state changes on its rising edge
//   RST               asynchronous, active-high reset
//   WA[12:0]          MCU address: WA[12:7] = row, WA[6:0] = column
//   WD[7:0]           MCU write data, RGB332
//   WE                MCU write strobe; sampled on every CLK
//   RD[7:0]           registered MCU read-back of mem[WA]; 0 when WA is out of range
//   ROUT/GOUT/BOUT    colour outputs: 3/3/2 bits
//   HS, VS            active-low sync outputs
//
// Pipeline, one pixel period (2 CLK) long:
//   pe=0 edge : disp_q <= mem[addr(h,v)]
//   pe=1 edge : RGB/HS/VS <= f(disp_q, h, v), and (h,v) advances
// All outputs therefore show pixel (h,v) one pixel period after the counters
// reach (h,v). RGB and sync stay aligned.
// -----------------------------------------------------------------------------
module vga_fb_display_ctrl #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SCALE_SHIFT = 3,
  parameter int FB_COLS     = 80,
  parameter int FB_ROWS     = 60
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [12:0] WA,
  input  logic [7:0]  WD,
  input  logic        WE,
  output logic [7:0]  RD,
  output logic [2:0]  ROUT,
  output logic [2:0]  GOUT,
  output logic [1:0]  BOUT,
  output logic        HS,
  output logic        VS
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  // Sync windows are written as [BEG, END), so END is exclusive.
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [6:0] COLS   = 7'(FB_COLS);
  localparam logic [5:0] ROWS   = 6'(FB_ROWS);

  // The framebuffer is addressed directly by {row, col}, so cells with
  // col >= FB_COLS are never written or read. It is not reset.
  logic [7:0]  mem [0:8191];

  logic        pe;
  logic [9:0]  h;
  logic [9:0]  v;
  logic        visible;
  logic        hs_n;
  logic        vs_n;
  logic        wa_ok;
  logic [12:0] disp_addr;
  logic [7:0]  disp_q;

  always_comb begin
    visible   = (h < H_VIS) && (v < V_VIS);
    disp_addr = '0;
    if (visible)
      disp_addr = {v[SCALE_SHIFT +: 6], h[SCALE_SHIFT +: 7]};
    hs_n  = !((h >= HS_BEG) && (h < HS_END));
    vs_n  = !((v >= VS_BEG) && (v < VS_END));
    wa_ok = (WA[6:0] < COLS) && (WA[12:7] < ROWS);
  end

  // Pixel enable and raster counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pe <= 1'b0;
      h  <= '0;
      v  <= '0;
    end else begin
      pe <= ~pe;
      if (pe) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
      end
    end
  end

  // MCU write port. Writes are independent of pe and of reset.
  always_ff @(posedge CLK) begin
    if (WE && wa_ok)
      mem[WA] <= WD;
  end

  // Display read port. The read happens on every CLK; only the value captured
  // on the pe=0 edge is used. A same-edge MCU write is not seen, so the old
  // data is shown.
  always_ff @(posedge CLK) begin
    disp_q <= mem[disp_addr];
  end

  // MCU read-back. This port also shows old data on a same-edge write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      RD <= 8'h00;
    else
      RD <= wa_ok ? mem[WA] : 8'h00;
  end

  // Output registers. disp_q already holds the data for the current (h,v).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ROUT <= '0;
      GOUT <= '0;
      BOUT <= '0;
      HS   <= 1'b1;
      VS   <= 1'b1;
    end else if (pe) begin
      ROUT <= visible ? disp_q[7:5] : 3'd0;
      GOUT <= visible ? disp_q[4:2] : 3'd0;
      BOUT <= visible ? disp_q[1:0] : 2'd0;
      HS   <= hs_n;
      VS   <= vs_n;
    end
  end

endmodule

// File: tb/tb_vga_fb_display_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for vga_fb_display_ctrl. The raster is scaled down so that several
// frames fit in a short run:
//   H: 64 visible, 4 front, 8 sync, 4 back  -> 80 pixels/line, 160 CLK/line
//   V: 32 visible, 2 front, 2 sync, 4 back  -> 40 lines, 6400 CLK/frame
// With these numbers the first HS fall comes 2*(64+4)+2 = 138 CLK after reset
// release. HS is low for 16 CLK, VS is low for 320 CLK, and VS has a period
// of 6400 CLK.
//
// Scoreboard operation:
//   - On every read edge (odd cycle after release), the pixel monitor pushes
//     the expected pixel, taken from the bench's own framebuffer image.
//   - It pops and compares that pixel on the next output edge.
//   - Each MCU drive cycle pushes its expected RD value; the value is popped
//     and checked one CLK later.
// -----------------------------------------------------------------------------
module tb_vga_fb_display_ctrl;

  localparam int HV = 64, HF = 4, HSW = 8, HB = 4;
  localparam int VV = 32, VF = 2, VSW = 2, VB = 4;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [12:0] wa  = '0;
  logic [7:0]  wd  = '0;
  logic        we  = 1'b0;
  logic [7:0]  rd;
  logic [2:0]  rout, gout;
  logic [1:0]  bout;
  logic        hs, vs;

  vga_fb_display_ctrl #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .SCALE_SHIFT(3), .FB_COLS(80), .FB_ROWS(60)
  ) dut (
    .CLK(clk), .RST(rst), .WA(wa), .WD(wd), .WE(we), .RD(rd),
    .ROUT(rout), .GOUT(gout), .BOUT(bout), .HS(hs), .VS(vs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
    int         p;
  } pix_t;

  typedef struct {
    logic       chk;
    logic [7:0] val;
  } rd_t;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] fb [0:8191];
  pix_t pq[$];
  rd_t  rq[$];
  rd_t  rd_cur;
  logic rd_have = 1'b0;
  int   cyc = 0;

  // Sync measurements, in cycles since reset release.
  logic hs_prev = 1'b1, vs_prev = 1'b1;
  int   hs_fall = -1, hs_first = -1, hs_per = -1, hs_low = -1;
  int   vs_fall = -1, vs_per = -1, vs_low = -1;

  // A pending MCU write is applied to the model one CLK later, just after the
  // edge on which the DUT performs it.
  logic        pend_we = 1'b0;
  logic [12:0] pend_wa = '0;
  logic [7:0]  pend_wd = '0;

  function automatic pix_t expect_pix(input int p);
    pix_t e;
    int hh, vv;
    hh = p % HT;
    vv = (p / HT) % VT;
    e.p   = p;
    e.rgb = ((hh < HV) && (vv < VV)) ? fb[(vv / 8) * 128 + (hh / 8)] : 8'h00;
    e.hs  = !((hh >= HV + HF) && (hh < HV + HF + HSW));
    e.vs  = !((vv >= VV + VF) && (vv < VV + VF + VSW));
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Posedge side: count cycles, push the expected pixel on each read edge,
  // and pop the expected RD value.
  always @(posedge clk) begin
    if (rst) begin
      cyc = 0;
      pq.delete();
    end else begin
      cyc++;
      if (cyc % 2 == 1)
        pq.push_back(expect_pix((cyc - 1) / 2));
    end
    rd_have = 1'b0;
    if (rq.size() > 0) begin
      rd_cur  = rq.pop_front();
      rd_have = 1'b1;
    end
  end

  // Negedge side: compare the video outputs and RD, and measure the sync timing.
  always @(negedge clk) begin
    pix_t e;
    if (rd_have && rd_cur.chk) begin
      n_vec++;
      if (rd !== rd_cur.val) begin
        n_err++;
        $display("FAIL rd: got %02h expected %02h", rd, rd_cur.val);
      end
    end
    if (rst || cyc < 2) begin
      n_vec++;
      if ({rout, gout, bout} !== 8'h00 || hs !== 1'b1 || vs !== 1'b1) begin
        n_err++;
        $display("FAIL reset_out: got rgb=%02h hs=%b vs=%b expected rgb=00 hs=1 vs=1",
                 {rout, gout, bout}, hs, vs);
      end
    end else if (cyc % 2 == 0) begin
      n_vec++;
      if (pq.size() == 0) begin
        n_err++;
        $display("FAIL pix_queue: empty at cycle %0d", cyc);
      end else begin
        e = pq.pop_front();
        if ({rout, gout, bout} !== e.rgb || hs !== e.hs || vs !== e.vs) begin
          n_err++;
          if (n_err < 40)
            $display("FAIL pixel p=%0d: got rgb=%02h hs=%b vs=%b expected rgb=%02h hs=%b vs=%b",
                     e.p, {rout, gout, bout}, hs, vs, e.rgb, e.hs, e.vs);
        end
      end
    end
    if (rst) begin
      hs_prev = 1'b1; vs_prev = 1'b1;
      hs_fall = -1; hs_first = -1; hs_per = -1; hs_low = -1;
      vs_fall = -1; vs_per = -1; vs_low = -1;
    end else begin
      if (hs_prev && !hs) begin
        if (hs_fall >= 0) hs_per = cyc - hs_fall;
        else              hs_first = cyc;
        hs_fall = cyc;
      end
      if (!hs_prev && hs && hs_fall >= 0) hs_low = cyc - hs_fall;
      if (vs_prev && !vs) begin
        if (vs_fall >= 0) vs_per = cyc - vs_fall;
        vs_fall = cyc;
      end
      if (!vs_prev && vs && vs_fall >= 0) vs_low = cyc - vs_fall;
      hs_prev = hs;
      vs_prev = vs;
    end
  end

  // One MCU cycle: drive WA/WD/WE after the edge and push the RD expected on
  // the following edge.
  task automatic drive(input logic [12:0] a, input logic [7:0] d, input logic w,
                       input logic chk, input logic [7:0] exp);
    @(posedge clk);
    #1;
    if (pend_we && pend_wa[6:0] < 7'd80 && pend_wa[12:7] < 6'd60)
      fb[pend_wa] = pend_wd;
    wa = a; wd = d; we = w;
    pend_we = w; pend_wa = a; pend_wd = d;
    rq.push_back('{chk, exp});
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 200 && cyc != target; i++) begin
      @(posedge clk);
      #1;
    end
    check("wait_cycle", cyc, target);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 8192; i++) fb[i] = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd", rd, 0);

    // Clear the visible cells while the DUT is held in reset, so the display
    // does not depend on the power-up contents of the RAM.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        drive({6'(r), 7'(c)}, 8'h00, 1'b1, 1'b0, 8'h00);
    drive(13'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Write cell (0,1) and read it back.
    drive(13'h0001, 8'hE0, 1'b1, 1'b1, 8'h00);
    drive(13'h0001, 8'h00, 1'b0, 1'b1, 8'hE0);
    drive(13'h0001, 8'h00, 1'b0, 1'b1, 8'hE0);
    // Column 80 is out of range: the write is ignored and the read returns 0.
    drive({6'd0, 7'd80}, 8'hFF, 1'b1, 1'b1, 8'h00);
    drive({6'd0, 7'd80}, 8'h00, 1'b0, 1'b1, 8'h00);
    // Row 60 is out of range as well.
    drive({6'd60, 7'd0}, 8'hFF, 1'b1, 1'b1, 8'h00);
    drive({6'd60, 7'd0}, 8'h00, 1'b0, 1'b1, 8'h00);
    // Read during write: old data on the write edge, new data on the next edge.
    drive(13'h0100, 8'h1C, 1'b1, 1'b1, 8'h00);
    drive(13'h0100, 8'h00, 1'b0, 1'b1, 8'h1C);
    // Two more cells, for extra colour patterns on screen.
    drive(13'h0082, 8'h1F, 1'b1, 1'b1, 8'h00);
    drive(13'h0187, 8'h4A, 1'b1, 1'b1, 8'h00);
    drive(13'h0187, 8'h00, 1'b0, 1'b1, 8'h4A);
    drive(13'h0082, 8'h00, 1'b0, 1'b1, 8'h1F);
    drive(13'h0000, 8'h00, 1'b0, 1'b1, 8'h00);

    // Free-run to cover more than two VS falls.
    repeat (14000) @(posedge clk);
    #1;
    check("hs_first_fall", hs_first, 138);
    check("hs_period", hs_per, 2 * HT);
    check("hs_low", hs_low, 2 * HSW);
    check("vs_period", vs_per, 2 * HT * VT);
    check("vs_low", vs_low, 2 * HT * VSW);

    // Reset mid-frame at line 20.
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (((cyc / 2) / HT) % VT == 20) found = 1'b1;
    end
    check("reach_v20", int'(found), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rgb", {rout, gout, bout}, 0);
    check("async_rst_hs", hs, 1);
    check("async_rst_vs", vs, 1);
    check("async_rst_rd", rd, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Pixel 7 (cell 0,0) is blank. Pixel 8 (cell 0,1) shows the retained E0.
    wait_cyc(16);
    @(negedge clk);
    check("px7_rgb", {rout, gout, bout}, 0);
    wait_cyc(18);
    @(negedge clk);
    check("px8_rout", rout, 7);
    check("px8_gout", gout, 0);
    check("px8_bout", bout, 0);

    repeat (7000) @(posedge clk);
    #1;
    check("restart_hs_first_fall", hs_first, 138);
    check("restart_hs_period", hs_per, 2 * HT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
